hm_mr: RTL and testbench

- PCIe TRN-interface (Virtex-6 style, 64-bit) memory-read request generator for the hm core.
- While the link is up, it repeatedly issues 1-DW, 32-bit-address Memory Read (MRd) TLPs on the TRN transmit port, using the endpoint's own requester ID.
- Counts accepted TLPs on stat_trn_cpt_tx.
- Drains and discards all received TLPs (completions included).

---
 rtl/hm_mr.sv | 194 +++++++++++++++++++
 tb/tb_hm_mr.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hm_mr.sv
// hm_mr: PCIe TRN (64-bit) memory-read request generator; drains and discards all RX traffic.
// Optional build macro HM_MR_ADDR_INC_EN walks the read address through the ADDR_MASK window.
module hm_mr #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK = 32'h0000_0FFC,
    parameter int unsigned GAP       = 8
) (
    input  logic        trn_clk,
    input  logic        sys_rst,
    input  logic        trn_reset_n,
    input  logic        trn_lnk_up_n,

    output logic [63:0] trn_td,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_trem_n,
    output logic        trn_tsrc_rdy_n,
    input  logic        trn_tdst_rdy_n,
    input  logic [5:0]  trn_tbuf_av,
    input  logic        trn_tcfg_req_n,
    input  logic        trn_terr_drop_n,
    output logic        trn_tsrc_dsc_n,
    output logic        trn_terrfwd_n,
    output logic        trn_tstr_n,
    output logic        trn_tcfg_gnt_n,

    input  logic [63:0] trn_rd,
    input  logic        trn_rrem_n,
    input  logic        trn_rsof_n,
    input  logic        trn_reof_n,
    input  logic        trn_rsrc_rdy_n,
    input  logic        trn_rsrc_dsc_n,
    input  logic        trn_rerrfwd_n,
    input  logic [6:0]  trn_rbar_hit_n,
    output logic        trn_rdst_rdy_n,
    output logic        trn_rnp_ok_n,

    input  logic [7:0]  cfg_bus_number,
    input  logic [4:0]  cfg_device_number,
    input  logic [2:0]  cfg_function_number,

    output logic [15:0] stat_trn_cpt_tx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_ADR,
        S_GAP
    } state_t;

    localparam logic [31:0] ADDR_INIT = {ADDR_BASE[31:2], 2'b00};
    // MRd, 32-bit address, TC0, no TD/EP, attr 0, length 1 DW.
    localparam logic [31:0] DW0       = 32'h0000_0001;
    localparam logic [15:0] GAP_LOAD  = (GAP > 1) ? 16'(GAP - 1) : 16'd0;

    state_t      state_q, state_nxt;
    logic [63:0] td_q, td_nxt;
    logic        tsof_n_q, tsof_n_nxt;
    logic        teof_n_q, teof_n_nxt;
    logic        trem_n_q, trem_n_nxt;
    logic        tsrc_rdy_n_q, tsrc_rdy_n_nxt;
    logic [7:0]  tag_q, tag_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic [15:0] cnt_q, cnt_nxt;
    logic [15:0] gap_q, gap_nxt;
    logic [31:0] addr_step;

`ifdef HM_MR_ADDR_INC_EN
    assign addr_step = ADDR_INIT | ((addr_q + 32'd4) & ADDR_MASK);
`else
    assign addr_step = ADDR_INIT;
`endif

    // Requester ID is captured into td at HDR entry, so it stays stable through any stall.
    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path can infer a latch.
        state_nxt      = state_q;
        td_nxt         = td_q;
        tsof_n_nxt     = tsof_n_q;
        teof_n_nxt     = teof_n_q;
        trem_n_nxt     = trem_n_q;
        tsrc_rdy_n_nxt = tsrc_rdy_n_q;
        tag_nxt        = tag_q;
        addr_nxt       = addr_q;
        cnt_nxt        = cnt_q;
        gap_nxt        = gap_q;

        if (!trn_reset_n) begin
            // Core reset clears the transmitter but keeps the statistics counter.
            state_nxt      = S_IDLE;
            td_nxt         = 64'h0;
            tsof_n_nxt     = 1'b1;
            teof_n_nxt     = 1'b1;
            trem_n_nxt     = 1'b0;
            tsrc_rdy_n_nxt = 1'b1;
            tag_nxt        = 8'h00;
            addr_nxt       = ADDR_INIT;
            gap_nxt        = 16'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!trn_lnk_up_n && (trn_tbuf_av != 6'd0)) begin
                        state_nxt      = S_HDR;
                        tsrc_rdy_n_nxt = 1'b0;
                        tsof_n_nxt     = 1'b0;
                        teof_n_nxt     = 1'b1;
                        trem_n_nxt     = 1'b0;
                        td_nxt         = {DW0, cfg_bus_number, cfg_device_number,
                                          cfg_function_number, tag_q, 4'b0000, 4'b1111};
                    end
                end
                S_HDR: begin
                    if (!trn_tdst_rdy_n) begin
                        state_nxt  = S_ADR;
                        tsof_n_nxt = 1'b1;
                        teof_n_nxt = 1'b0;
                        trem_n_nxt = 1'b1;
                        td_nxt     = {addr_q[31:2], 2'b00, 32'h0};
                    end
                end
                S_ADR: begin
                    if (!trn_tdst_rdy_n) begin
                        state_nxt      = S_GAP;
                        tsrc_rdy_n_nxt = 1'b1;
                        teof_n_nxt     = 1'b1;
                        trem_n_nxt     = 1'b0;
                        td_nxt         = 64'h0;
                        cnt_nxt        = cnt_q + 16'd1;
                        tag_nxt        = tag_q + 8'd1;
                        addr_nxt       = addr_step;
                        gap_nxt        = GAP_LOAD;
                    end
                end
                S_GAP: begin
                    if (gap_q == 16'd0) begin
                        state_nxt = S_IDLE;
                    end else begin
                        gap_nxt = gap_q - 16'd1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge trn_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            td_q         <= 64'h0;
            tsof_n_q     <= 1'b1;
            teof_n_q     <= 1'b1;
            trem_n_q     <= 1'b0;
            tsrc_rdy_n_q <= 1'b1;
            tag_q        <= 8'h00;
            addr_q       <= ADDR_INIT;
            cnt_q        <= 16'h0;
            gap_q        <= 16'h0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q      <= state_nxt;
            td_q         <= td_nxt;
            tsof_n_q     <= tsof_n_nxt;
            teof_n_q     <= teof_n_nxt;
            trem_n_q     <= trem_n_nxt;
            tsrc_rdy_n_q <= tsrc_rdy_n_nxt;
            tag_q        <= tag_nxt;
            addr_q       <= addr_nxt;
            cnt_q        <= cnt_nxt;
            gap_q        <= gap_nxt;
        end
    end

    assign trn_td          = td_q;
    assign trn_tsof_n      = tsof_n_q;
    assign trn_teof_n      = teof_n_q;
    assign trn_trem_n      = trem_n_q;
    assign trn_tsrc_rdy_n  = tsrc_rdy_n_q;
    assign stat_trn_cpt_tx = cnt_q;

    assign trn_tsrc_dsc_n  = 1'b1;
    assign trn_terrfwd_n   = 1'b1;
    assign trn_tstr_n      = 1'b1;
    assign trn_tcfg_gnt_n  = 1'b0;
    assign trn_rdst_rdy_n  = 1'b0;
    assign trn_rnp_ok_n    = 1'b0;

    // Receive side and config-request/drop indications are intentionally ignored.
    logic unused_inputs;
    assign unused_inputs = ^{trn_tcfg_req_n, trn_terr_drop_n, trn_rd, trn_rrem_n, trn_rsof_n,
                             trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rerrfwd_n,
                             trn_rbar_hit_n, addr_q[1:0]};

endmodule

// File: tb/tb_hm_mr.sv
// tb_hm_mr: directed bench for hm_mr (defaults ADDR_BASE=0, ADDR_MASK=0xFFC, GAP=8).
// Address expectations follow HM_MR_ADDR_INC_EN when the bench is built with it.
module tb_hm_mr;

    logic        trn_clk;
    logic        sys_rst;
    logic        trn_reset_n;
    logic        trn_lnk_up_n;
    logic [63:0] trn_td;
    logic        trn_tsof_n, trn_teof_n, trn_trem_n, trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n;
    logic [5:0]  trn_tbuf_av;
    logic        trn_tcfg_req_n, trn_terr_drop_n;
    logic        trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n, trn_tcfg_gnt_n;
    logic [63:0] trn_rd;
    logic        trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rerrfwd_n;
    logic [6:0]  trn_rbar_hit_n;
    logic        trn_rdst_rdy_n, trn_rnp_ok_n;
    logic [7:0]  cfg_bus_number;
    logic [4:0]  cfg_device_number;
    logic [2:0]  cfg_function_number;
    logic [15:0] stat_trn_cpt_tx;

    int n_checks = 0;
    int n_errors = 0;

`ifdef HM_MR_ADDR_INC_EN
    localparam int N_RUN = 1025;
`else
    localparam int N_RUN = 260;
`endif

    hm_mr dut (
        .trn_clk             (trn_clk),
        .sys_rst             (sys_rst),
        .trn_reset_n         (trn_reset_n),
        .trn_lnk_up_n        (trn_lnk_up_n),
        .trn_td              (trn_td),
        .trn_tsof_n          (trn_tsof_n),
        .trn_teof_n          (trn_teof_n),
        .trn_trem_n          (trn_trem_n),
        .trn_tsrc_rdy_n      (trn_tsrc_rdy_n),
        .trn_tdst_rdy_n      (trn_tdst_rdy_n),
        .trn_tbuf_av         (trn_tbuf_av),
        .trn_tcfg_req_n      (trn_tcfg_req_n),
        .trn_terr_drop_n     (trn_terr_drop_n),
        .trn_tsrc_dsc_n      (trn_tsrc_dsc_n),
        .trn_terrfwd_n       (trn_terrfwd_n),
        .trn_tstr_n          (trn_tstr_n),
        .trn_tcfg_gnt_n      (trn_tcfg_gnt_n),
        .trn_rd              (trn_rd),
        .trn_rrem_n          (trn_rrem_n),
        .trn_rsof_n          (trn_rsof_n),
        .trn_reof_n          (trn_reof_n),
        .trn_rsrc_rdy_n      (trn_rsrc_rdy_n),
        .trn_rsrc_dsc_n      (trn_rsrc_dsc_n),
        .trn_rerrfwd_n       (trn_rerrfwd_n),
        .trn_rbar_hit_n      (trn_rbar_hit_n),
        .trn_rdst_rdy_n      (trn_rdst_rdy_n),
        .trn_rnp_ok_n        (trn_rnp_ok_n),
        .cfg_bus_number      (cfg_bus_number),
        .cfg_device_number   (cfg_device_number),
        .cfg_function_number (cfg_function_number),
        .stat_trn_cpt_tx     (stat_trn_cpt_tx)
    );

    initial trn_clk = 1'b0;
    always #5 trn_clk = ~trn_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    // Beat 0 for bus 0x18, dev 0, func 0: DW0 = 0x00000001, DW1 = {16'h1800, tag, 8'h0F}.
    function automatic logic [63:0] exp_hdr(input int tlp_idx);
        logic [7:0] t;
        t = 8'((tlp_idx - 1) & 255);
        return {32'h0000_0001, 16'h1800, t, 8'h0F};
    endfunction

    function automatic logic [63:0] exp_adr(input int tlp_idx);
`ifdef HM_MR_ADDR_INC_EN
        logic [31:0] a;
        a = 32'((tlp_idx - 1) * 4) & 32'h0000_0FFC;
        return {a, 32'h0};
`else
        return (tlp_idx > 0) ? 64'h0 : 64'h0;
`endif
    endfunction

    task automatic wait_sof(output int waited);
        waited = 0;
        while (!(trn_tsrc_rdy_n == 1'b0 && trn_tsof_n == 1'b0) && waited < 40) begin
            @(negedge trn_clk);
            waited++;
        end
        check("sof_within_budget", 64'(waited < 40), 64'd1);
    endtask

    // Captures one unstalled TLP; returns on the first GAP cycle.
    task automatic next_tlp(output logic [63:0] b0, output logic [63:0] b1, output int waited);
        wait_sof(waited);
        b0 = trn_td;
        @(negedge trn_clk);
        b1 = trn_td;
        @(negedge trn_clk);
    endtask

    initial begin
        logic [63:0] b0, b1;
        int w;
        int sof_seen;

        sys_rst = 1'b1;
        trn_reset_n = 1'b1;
        trn_lnk_up_n = 1'b1;
        trn_tdst_rdy_n = 1'b1;
        trn_tbuf_av = 6'h3F;
        trn_tcfg_req_n = 1'b0;
        trn_terr_drop_n = 1'b1;
        trn_rd = 64'hDEAD_BEEF_0123_4567;
        trn_rrem_n = 1'b0;
        trn_rsof_n = 1'b1;
        trn_reof_n = 1'b1;
        trn_rsrc_rdy_n = 1'b1;
        trn_rsrc_dsc_n = 1'b1;
        trn_rerrfwd_n = 1'b1;
        trn_rbar_hit_n = 7'h7F;
        cfg_bus_number = 8'h18;
        cfg_device_number = 5'd0;
        cfg_function_number = 3'd0;

        repeat (3) @(negedge trn_clk);
        check("rst_tsrc_rdy_n", 64'(trn_tsrc_rdy_n), 64'd1);
        check("rst_cnt", 64'(stat_trn_cpt_tx), 64'd0);
        check("rst_rdst_rdy_n", 64'(trn_rdst_rdy_n), 64'd0);
        check("rst_tcfg_gnt_n", 64'(trn_tcfg_gnt_n), 64'd0);
        check("rst_td", trn_td, 64'h0);
        check("rst_sof_eof_rem", 64'({trn_tsof_n, trn_teof_n, trn_trem_n}), 64'b110);
        check("const_dsc_fwd_str", 64'({trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n}), 64'b111);
        check("const_rnp_ok_n", 64'(trn_rnp_ok_n), 64'd0);

        sys_rst = 1'b0;
        @(negedge trn_clk);
        check("idle_link_down", 64'(trn_tsrc_rdy_n), 64'd1);

        // First TLP, stalled 8 cycles; bus changes mid-stall must not disturb the header.
        trn_lnk_up_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge trn_clk);
            check("tlp1_beat0_td", trn_td, 64'h0000_0001_1800_000F);
            check("tlp1_beat0_ctl", 64'({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n}), 64'b0010);
            if (i == 3) cfg_bus_number = 8'h55;
        end
        cfg_bus_number = 8'h18;
        trn_tdst_rdy_n = 1'b0;
        @(negedge trn_clk);
        check("tlp1_beat1_td", trn_td, 64'h0);
        check("tlp1_beat1_ctl", 64'({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n}), 64'b0101);
        check("tlp1_cnt_before", 64'(stat_trn_cpt_tx), 64'd0);
        @(negedge trn_clk);
        check("tlp1_cnt_after", 64'(stat_trn_cpt_tx), 64'd1);
        check("tlp1_released", 64'(trn_tsrc_rdy_n), 64'd1);

        trn_terr_drop_n = 1'b0;
        for (int idx = 2; idx <= N_RUN; idx++) begin
            next_tlp(b0, b1, w);
            if (idx == 3) trn_terr_drop_n = 1'b1;
            if (idx <= 4 || idx == 256 || idx == 257 || idx >= N_RUN - 1) begin
                check($sformatf("tlp%0d_hdr", idx), b0, exp_hdr(idx));
                check($sformatf("tlp%0d_adr", idx), b1, exp_adr(idx));
                check($sformatf("tlp%0d_period", idx), 64'(w + 2), 64'd11);
                check($sformatf("tlp%0d_cnt", idx), 64'(stat_trn_cpt_tx), 64'(idx));
            end
        end

        // Link drops while the header is stalled: the TLP still completes.
        trn_tdst_rdy_n = 1'b1;
        wait_sof(w);
        trn_lnk_up_n = 1'b1;
        @(negedge trn_clk);
        check("lnk_dn_hdr_held", 64'({trn_tsrc_rdy_n, trn_tsof_n}), 64'b00);
        check("lnk_dn_hdr_td", trn_td, exp_hdr(N_RUN + 1));
        trn_tdst_rdy_n = 1'b0;
        @(negedge trn_clk);
        check("lnk_dn_beat1", 64'({trn_tsrc_rdy_n, trn_teof_n}), 64'b00);
        @(negedge trn_clk);
        check("lnk_dn_cnt", 64'(stat_trn_cpt_tx), 64'(N_RUN + 1));
        sof_seen = 0;
        repeat (30) begin
            @(negedge trn_clk);
            if (trn_tsrc_rdy_n == 1'b0) sof_seen++;
        end
        check("lnk_dn_no_new_tlp", 64'(sof_seen), 64'd0);
        trn_lnk_up_n = 1'b0;
        wait_sof(w);
        check("lnk_up_restart", 64'(trn_tsof_n), 64'd0);

        // Asynchronous reset while the address beat is on the bus.
        @(negedge trn_clk);
        check("pre_rst_adr_beat", 64'(trn_teof_n), 64'd0);
        sys_rst = 1'b1;
        #1;
        check("mid_rst_ctl", 64'({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n}), 64'b1110);
        check("mid_rst_td", trn_td, 64'h0);
        check("mid_rst_cnt", 64'(stat_trn_cpt_tx), 64'd0);
        @(negedge trn_clk);
        sys_rst = 1'b0;
        next_tlp(b0, b1, w);
        check("post_rst_hdr", b0, 64'h0000_0001_1800_000F);
        check("post_rst_adr", b1, 64'h0);
        check("post_rst_cnt", 64'(stat_trn_cpt_tx), 64'd1);

        // Core reset aborts a stalled header, clears the tag and keeps the count.
        trn_tdst_rdy_n = 1'b1;
        wait_sof(w);
        trn_reset_n = 1'b0;
        @(negedge trn_clk);
        check("core_rst_ctl", 64'({trn_tsrc_rdy_n, trn_tsof_n}), 64'b11);
        check("core_rst_td", trn_td, 64'h0);
        check("core_rst_cnt_hold", 64'(stat_trn_cpt_tx), 64'd1);
        trn_reset_n = 1'b1;
        trn_tdst_rdy_n = 1'b0;
        next_tlp(b0, b1, w);
        check("core_rst_tag0", b0, 64'h0000_0001_1800_000F);
        check("core_rst_cnt_next", 64'(stat_trn_cpt_tx), 64'd2);

        // No transmit buffers: nothing starts.
        trn_tbuf_av = 6'd0;
        sof_seen = 0;
        repeat (25) begin
            @(negedge trn_clk);
            if (trn_tsrc_rdy_n == 1'b0) sof_seen++;
        end
        check("tbuf_empty_no_tlp", 64'(sof_seen), 64'd0);
        trn_tbuf_av = 6'd1;
        wait_sof(w);
        check("tbuf_avail_hdr", trn_td, {32'h0000_0001, 16'h1800, 8'h01, 8'h0F});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
